// File: rtl/memory_pkg.sv
// Shared memory-map constants, master id and response types for the data-memory arbiter.
package memory_pkg;

  localparam logic [31:0] MAP_DMEM_BASE   = 32'h1000_0000;
  localparam int unsigned DMEM_SIZE_BYTES = 4096;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned BE_W            = 4;

  typedef logic [0:0] master_id_t;

  typedef struct packed {
    logic              valid;
    master_id_t        id;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } resp_t;

  // Offset compare avoids any overflow of base + size near the top of the address space
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] size);
    logic [ADDR_W-1:0] offset;
    offset = addr - base;
    return (addr >= base) && (offset <= (size - ADDR_W'(1)));
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the grant is combinational, last_grant is the only state.
module rr_arb2
  import memory_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt_o        = 2'b00;
    last_grant_d = last_grant_q;
    if (req_i == 2'b11) begin
      gnt_o = last_grant_q ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
    if (gnt_o[1]) begin
      last_grant_d = 1'b1;
    end else if (gnt_o[0]) begin
      last_grant_d = 1'b0;
    end
  end

  // Reset to master 1 so master 0 wins the first tie
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: same-cycle grant and memory access, fixed one-cycle response.
module dmem_arbiter
  import memory_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = MAP_DMEM_BASE,
  parameter int unsigned SIZE_BYTES = DMEM_SIZE_BYTES
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  logic [1:0]  req_v;
  logic [1:0]  gnt;
  logic        gnt_any;
  master_id_t  win_id;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_in_win;
  resp_t       resp_q;
  resp_t       resp_d;

  // Requests are masked during reset so no grant or memory access can leak out
  assign req_v = {m1_req_i, m0_req_i} & {2{~rst_i}};

  rr_arb2 u_rr_arb2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_v),
    .gnt_o (gnt)
  );

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];
  assign gnt_any  = |gnt;
  assign win_id   = master_id_t'(gnt[1]);

  always_comb begin
    sel_we     = m0_we_i;
    sel_be     = m0_be_i;
    sel_addr   = m0_addr_i;
    sel_wdata  = m0_wdata_i;
    if (win_id == master_id_t'(1)) begin
      sel_we    = m1_we_i;
      sel_be    = m1_be_i;
      sel_addr  = m1_addr_i;
      sel_wdata = m1_wdata_i;
    end
    sel_in_win = in_window(sel_addr, BASE_ADDR, 32'(SIZE_BYTES));
  end

  always_comb begin
    mem_req_o   = gnt_any && sel_in_win;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (mem_req_o) begin
      mem_we_o    = sel_we;
      mem_be_o    = sel_be;
      mem_addr_o  = sel_addr;
      mem_wdata_o = sel_wdata;
    end
  end

  always_comb begin
    resp_d       = '0;
    resp_d.valid = gnt_any;
    resp_d.id    = win_id;
    resp_d.err   = gnt_any && !sel_in_win;
    if (gnt_any && sel_in_win && !sel_we) begin
      resp_d.rdata = mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_d;
    end
  end

  // Only the master that owns the pending response sees anything non-zero
  always_comb begin
    m0_rvalid_o = 1'b0;
    m0_err_o    = 1'b0;
    m0_rdata_o  = 32'h0;
    m1_rvalid_o = 1'b0;
    m1_err_o    = 1'b0;
    m1_rdata_o  = 32'h0;
    if (resp_q.valid) begin
      if (resp_q.id == master_id_t'(0)) begin
        m0_rvalid_o = 1'b1;
        m0_err_o    = resp_q.err;
        m0_rdata_o  = resp_q.rdata;
      end else begin
        m1_rvalid_o = 1'b1;
        m1_err_o    = resp_q.err;
        m1_rdata_o  = resp_q.rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random traffic for dmem_arbiter against hand-computed values and a reference memory.
module tb_dmem_arbiter;
  import memory_pkg::*;

  localparam logic [31:0] B = MAP_DMEM_BASE;
  localparam int unsigned NWORDS = DMEM_SIZE_BYTES / 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        bd_clr, bd_we;
  logic [9:0]  bd_idx;
  logic [31:0] bd_data;
  logic [31:0] mem [NWORDS];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Environment memory behind the native port, plus a backdoor for preloading
  always @(posedge clk) begin
    if (bd_clr) begin
      for (int i = 0; i < int'(NWORDS); i++) mem[i] <= 32'h0;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (mem_req && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end
  assign mem_rdata = mem[mem_addr[11:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drv(input int n, input logic req, input logic we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wd);
    if (n == 0) begin
      m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  logic        r_req [2];
  logic        r_we [2];
  logic [3:0]  r_be [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wd [2];
  logic [31:0] ref_mem [NWORDS];
  logic        p_valid, p_id, p_err, last, in_w, hit;
  logic [31:0] p_rdata, e_rdata;
  logic [1:0]  e_gnt;
  int          w, k;
  logic [9:0]  idx;

  initial begin
    rst = 1'b1; bd_clr = 1'b0; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    drv(0, 1'b1, 1'b0, 4'hF, B, 32'h0);
    drv(1, 1'b1, 1'b0, 4'hF, B + 32'h4, 32'h0);
    @(negedge clk); @(negedge clk); #1;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);

    @(negedge clk); rst = 1'b0; bd_clr = 1'b1;
    drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); drv(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk); bd_clr = 1'b0; bd_we = 1'b1; bd_idx = 10'd0; bd_data = 32'hDEADBEEF;
    @(negedge clk); bd_idx = 10'd1023; bd_data = 32'hCAFEF00D;
    @(negedge clk); bd_we = 1'b0;

    // Single read by m0
    drv(0, 1'b1, 1'b0, 4'hF, B, 32'h0); #1;
    chk("rd_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("rd_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rd_mem_req", 32'(mem_req), 32'd1);
    chk("rd_mem_addr", mem_addr, B);
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk); drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m0_err", 32'(m0_err), 32'd0);
    chk("rd_m1_rvalid", 32'(m1_rvalid), 32'd0);

    // Continuous contention right after reset alternates m0,m1,m0,m1
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    drv(0, 1'b1, 1'b0, 4'hF, B, 32'h0); drv(1, 1'b1, 1'b0, 4'hF, B + 32'h4, 32'h0); #1;
    chk("rr0_gnt", {30'd0, m1_gnt, m0_gnt}, 32'b01);
    chk("rr0_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'b00);
    @(negedge clk); #1;
    chk("rr1_gnt", {30'd0, m1_gnt, m0_gnt}, 32'b10);
    chk("rr1_mem_addr", mem_addr, B + 32'h4);
    chk("rr1_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'b01);
    chk("rr1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("rr2_gnt", {30'd0, m1_gnt, m0_gnt}, 32'b01);
    chk("rr2_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'b10);
    chk("rr2_m0_rdata", m0_rdata, 32'h0);
    @(negedge clk); #1;
    chk("rr3_gnt", {30'd0, m1_gnt, m0_gnt}, 32'b10);
    chk("rr3_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'b01);
    @(negedge clk); drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); drv(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("rr4_gnt", {30'd0, m1_gnt, m0_gnt}, 32'b00);
    chk("rr4_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'b10);

    // Word write, byte write, read-back merge by m1
    @(negedge clk); drv(1, 1'b1, 1'b1, 4'hF, B + 32'h8, 32'h11223344); #1;
    chk("sw_m1_gnt", 32'(m1_gnt), 32'd1);
    chk("sw_mem_we", 32'(mem_we), 32'd1);
    chk("sw_mem_wdata", mem_wdata, 32'h11223344);
    @(negedge clk); drv(1, 1'b1, 1'b1, 4'b0010, B + 32'h8, 32'h0000AA00); #1;
    chk("sw_m1_rvalid", 32'(m1_rvalid), 32'd1);
    chk("sw_m1_rdata", m1_rdata, 32'h0);
    chk("sb_mem_be", 32'(mem_be), 32'h2);
    @(negedge clk); drv(1, 1'b1, 1'b0, 4'hF, B + 32'h8, 32'h0); #1;
    chk("lw_m1_gnt", 32'(m1_gnt), 32'd1);
    @(negedge clk); drv(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("lw_m1_rvalid", 32'(m1_rvalid), 32'd1);
    chk("lw_m1_rdata", m1_rdata, 32'h1122AA44);
    chk("lw_m0_rvalid", 32'(m0_rvalid), 32'd0);

    // Window boundaries
    @(negedge clk); drv(0, 1'b1, 1'b0, 4'hF, B + 32'h1000, 32'h0); #1;
    chk("oow_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("oow_mem_req", 32'(mem_req), 32'd0);
    chk("oow_mem_addr", mem_addr, 32'h0);
    @(negedge clk); drv(0, 1'b1, 1'b0, 4'hF, B + 32'hFFC, 32'h0); #1;
    chk("oow_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("oow_m0_err", 32'(m0_err), 32'd1);
    chk("oow_m0_rdata", m0_rdata, 32'h0);
    chk("top_mem_req", 32'(mem_req), 32'd1);
    @(negedge clk); drv(0, 1'b1, 1'b0, 4'hF, B - 32'h4, 32'h0); #1;
    chk("top_m0_err", 32'(m0_err), 32'd0);
    chk("top_m0_rdata", m0_rdata, 32'hCAFEF00D);
    chk("below_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk); drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("below_m0_err", 32'(m0_err), 32'd1);

    // be=0 write is a harmless no-op
    @(negedge clk); drv(0, 1'b1, 1'b1, 4'h0, B + 32'h8, 32'hFFFFFFFF); #1;
    chk("be0_mem_req", 32'(mem_req), 32'd1);
    chk("be0_mem_be", 32'(mem_be), 32'h0);
    @(negedge clk); drv(0, 1'b1, 1'b0, 4'hF, B + 32'h8, 32'h0); #1;
    chk("be0_m0_err", 32'(m0_err), 32'd0);
    @(negedge clk); drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("be0_rd_rdata", m0_rdata, 32'h1122AA44);

    // Reset while a response is pending
    @(negedge clk); drv(0, 1'b1, 1'b0, 4'hF, B, 32'h0); #1;
    chk("rp_m0_gnt", 32'(m0_gnt), 32'd1);
    @(negedge clk); drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); rst = 1'b1; #1;
    chk("rp_rvalid_drop", 32'(m0_rvalid), 32'd0);
    @(negedge clk); rst = 1'b0;
    drv(0, 1'b1, 1'b0, 4'hF, B, 32'h0); drv(1, 1'b1, 1'b0, 4'hF, B + 32'h8, 32'h0); #1;
    chk("rp_tie_gnt", {30'd0, m1_gnt, m0_gnt}, 32'b01);
    chk("rp_no_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'b00);
    @(negedge clk); drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("rp_m1_gnt", {30'd0, m1_gnt, m0_gnt}, 32'b10);
    chk("rp_m0_rdata", m0_rdata, 32'hDEADBEEF);
    @(negedge clk); drv(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("rp_m1_rdata", m1_rdata, 32'h1122AA44);

    // Random two-master traffic against a reference memory and arbitration model
    @(negedge clk); rst = 1'b1; bd_clr = 1'b1;
    @(negedge clk); rst = 1'b0; bd_clr = 1'b0;
    for (int i = 0; i < int'(NWORDS); i++) ref_mem[i] = 32'h0;
    for (int n = 0; n < 2; n++) begin
      r_req[n] = 1'b0; r_we[n] = 1'b0; r_be[n] = 4'h0; r_addr[n] = 32'h0; r_wd[n] = 32'h0;
    end
    p_valid = 1'b0; p_id = 1'b0; p_err = 1'b0; p_rdata = 32'h0; last = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!r_req[n] && ($urandom_range(0, 1) == 1)) begin
          r_req[n] = 1'b1;
          r_we[n]  = 1'($urandom_range(0, 1));
          r_be[n]  = 4'($urandom_range(0, 15));
          r_wd[n]  = $urandom;
          k = int'($urandom_range(0, 15));
          if (k == 0)      r_addr[n] = B + 32'h1000 + 32'(4 * $urandom_range(0, 3));
          else if (k == 1) r_addr[n] = B - 32'h4;
          else             r_addr[n] = B + 32'(4 * $urandom_range(0, 15));
        end
        drv(n, r_req[n], r_we[n], r_be[n], r_addr[n], r_wd[n]);
      end
      #1;
      hit = p_valid && !p_id;
      chk("rnd_m0_rvalid", 32'(m0_rvalid), 32'(hit));
      chk("rnd_m0_err", 32'(m0_err), hit ? 32'(p_err) : 32'd0);
      chk("rnd_m0_rdata", m0_rdata, hit ? p_rdata : 32'h0);
      hit = p_valid && p_id;
      chk("rnd_m1_rvalid", 32'(m1_rvalid), 32'(hit));
      chk("rnd_m1_err", 32'(m1_err), hit ? 32'(p_err) : 32'd0);
      chk("rnd_m1_rdata", m1_rdata, hit ? p_rdata : 32'h0);
      if (r_req[0] && r_req[1]) w = last ? 0 : 1;
      else if (r_req[0])        w = 0;
      else if (r_req[1])        w = 1;
      else                      w = -1;
      e_gnt = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
      chk("rnd_gnt", {30'd0, m1_gnt, m0_gnt}, 32'(e_gnt));
      if (w >= 0) begin
        in_w = (r_addr[w] >= B) && ((r_addr[w] - B) <= 32'hFFF);
        chk("rnd_mem_req", 32'(mem_req), 32'(in_w));
        idx = 10'((r_addr[w] - B) >> 2);
        e_rdata = (in_w && !r_we[w]) ? ref_mem[idx] : 32'h0;
        if (in_w && r_we[w])
          for (int b = 0; b < 4; b++)
            if (r_be[w][b]) ref_mem[idx][8*b +: 8] = r_wd[w][8*b +: 8];
        p_valid = 1'b1; p_id = (w == 1); p_err = !in_w; p_rdata = e_rdata;
        last = (w == 1);
        r_req[w] = 1'b0;
      end else begin
        p_valid = 1'b0; p_id = 1'b0; p_err = 1'b0; p_rdata = 32'h0;
      end
    end
    @(negedge clk);
    drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); drv(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("rnd_last_rvalid", {30'd0, m1_rvalid, m0_rvalid},
        p_valid ? (p_id ? 32'b10 : 32'b01) : 32'b00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter BASE_ADDR, default memory_pkg::MAP_DMEM_BASE: byte base address of the data memory window.
REQ-002 Parameter SIZE_BYTES, default memory_pkg::DMEM_SIZE_BYTES: window size in bytes; a multiple of 4.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous and active-high.
REQ-005 mN_req_i  in  1  access request from master N (N=0 core LSU, N=1 DMA/debug); held until granted.
REQ-006 mN_we_i  in  1  1=write, 0=read.
REQ-007 mN_be_i  in  4  byte enables (SB/SH/SW).
REQ-008 mN_addr_i  in  32  byte address.
REQ-009 mN_wdata_i  in  32  write data.
REQ-010 mN_gnt_o  out  1  request accepted this cycle.
REQ-011 mN_rvalid_o  out  1  one-cycle response strobe for the accepted access.
REQ-012 mN_rdata_o  out  32  read data; valid with rvalid, 0 for writes and errors.
REQ-013 mN_err_o  out  1  out-of-window error; valid with rvalid.
REQ-014 mem_req_o, mem_we_o (1), mem_be_o (4), mem_addr_o (32), mem_wdata_o (32)  out  native DMEM port.
REQ-015 mem_rdata_i  in  32  combinational DMEM read data.

Function
REQ-016 At most one gnt per cycle; gnt is combinational from req and arbitration state.
REQ-017 A single requester is granted in the same cycle.
REQ-018 Both requesting: grant the master not granted most recently (round-robin); last_grant updates only on a grant.
REQ-019 Granted in-window access: mem_req_o=1 and the mem_* fields equal the winner's fields in the same cycle; otherwise all mem_* outputs are 0.
REQ-020 In-window: BASE_ADDR <= addr <= BASE_ADDR+SIZE_BYTES-1, with the subtraction done in 32-bit unsigned arithmetic and no wrap past 2^32.
REQ-021 Out-of-window grant: no memory access; response has err=1, rdata=0.
REQ-022 The response register captures {master id, err, rdata = mem_rdata_i if read and in-window, else 0} at the edge ending the grant cycle.
REQ-023 The targeted rvalid is high for exactly the following cycle; the other master's rvalid, err and rdata stay 0.
REQ-024 Latency is fixed: gnt in cycle T, rvalid in T+1; back-to-back grants are allowed, so throughput is 1 access/cycle.
REQ-025 A master may request again in the cycle its rvalid is high; that grant follows REQ-018.
REQ-026 A write followed by a read of the same word on the next grant returns the written bytes merged under be.
REQ-027 be=0 writes are forwarded unchanged (no-op in memory) and respond err=0.

Reset
REQ-028 While rst_i=1, all gnt, rvalid, err, rdata and mem_* outputs are 0, the response register is cleared and last_grant=1, so master 0 wins the first tie.
REQ-029 Reset asserted while a response is pending drops the response; no rvalid is issued after reset release.
REQ-030 In the first cycle after release, a pending request is granted per REQ-017/018.

Structure
REQ-031 Master ID type (logic [0:0]) and the response struct {valid, id, err, rdata} are defined in memory_pkg; BASE/SIZE defaults come from memory_pkg.
REQ-032 The two-way round-robin decision is a sub-module rr_arb2 (req[1:0], gnt[1:0], last_grant state).

Verification
REQ-033 m0 reads 0x...0 alone, memory word=0xDEADBEEF -> m0_gnt in T; m0_rvalid=1, rdata=0xDEADBEEF in T+1.
REQ-034 m0 and m1 request continuously for 4 cycles after reset -> grants m0,m1,m0,m1; rvalid pattern is the same, delayed by 1.
REQ-035 m1 SW 0x11223344 then SB be=0010 data 0x0000AA00, then read -> 0x1122AA44.
REQ-036 m0 reads BASE_ADDR+SIZE_BYTES -> mem_req_o=0; T+1 err=1, rdata=0; next in-window read is err=0.
REQ-037 Reset pulsed in the cycle after a grant -> no rvalid after release; first tie goes to m0.
REQ-038 Random 10k-cycle two-master traffic vs. a reference memory model -> every read matches and no rvalid is lost or duplicated.
